// File: rtl/lsu_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_access_ctrl
// Brief    : Load/store access controller between the execute stage and a
//            128-bit-line data memory. Drives a req/gnt/rvalid handshake,
//            formats store byte enables and replicated write data, and hands
//            the captured load line plus access flags to the load selector.
//            Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem_access_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_load,
    input  logic                   req_store,
    input  logic                   req_lb,
    input  logic                   req_lh,
    input  logic                   req_lw,
    input  logic                   req_unsigned,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   dmem_req,
    input  logic                   dmem_gnt,
    output logic                   dmem_we,
    output logic [ADDR_WIDTH-1:0]  dmem_addr,
    output logic [15:0]            dmem_be,
    output logic [LINE_WIDTH-1:0]  dmem_wdata,
    input  logic                   dmem_rvalid,
    input  logic [LINE_WIDTH-1:0]  dmem_rdata,
    output logic                   sel_lb,
    output logic                   sel_lh,
    output logic                   sel_lw,
    output logic                   sel_unsigned,
    output logic [OFFSET_BITS-1:0] sel_addr,
    output logic [LINE_WIDTH-1:0]  sel_rd_data,
    output logic                   resp_valid,
    output logic                   resp_is_load,
    output logic                   lsu_stall,
    output logic                   misalign_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_WAIT_RD = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_load;
    logic                  r_lb;
    logic                  r_lh;
    logic                  r_lw;
    logic                  r_unsigned;
    logic [31:0]           r_wdata;
    logic [LINE_WIDTH-1:0] r_rd_data;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_capture;
    logic [15:0]           w_be;
    logic [LINE_WIDTH-1:0] w_wdata;

    // A request is well formed only with exactly one direction and one width.
    assign w_accept = (r_state == c_IDLE) & req_valid
                    & (req_load ^ req_store)
                    & ((req_lb & ~req_lh & ~req_lw) |
                       (~req_lb & req_lh & ~req_lw) |
                       (~req_lb & ~req_lh & req_lw));

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;
    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    assign w_misalign   = (req_lh & req_addr[0]) | (req_lw & (req_addr[1:0] != 2'b00));
    assign misalign_err = (r_state == c_RESP) & r_misalign;
`else
    // Without the trap, the low address bits below the access width are ignored.
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Load line is captured either together with the grant or later in WAIT_RD.
    assign w_capture = r_load & dmem_rvalid &
                       (((r_state == c_REQ) & dmem_gnt) | (r_state == c_WAIT_RD));

    // Next-state logic for the request/response sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misalign ? c_RESP : c_REQ;
                end
            end
            c_REQ: begin
                if (dmem_gnt) begin
                    w_state_nxt = (!r_load || dmem_rvalid) ? c_RESP : c_WAIT_RD;
                end
            end
            c_WAIT_RD: begin
                if (dmem_rvalid) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, request latch and load-line capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_load     <= 1'b0;
            r_lb       <= 1'b0;
            r_lh       <= 1'b0;
            r_lw       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_load     <= req_load;
                r_lb       <= req_lb;
                r_lh       <= req_lh;
                r_lw       <= req_lw;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                r_misalign <= w_misalign;
`endif
            end
            if (w_capture) begin
                r_rd_data <= dmem_rdata;
            end
        end
    end

    // Store formatting: data replicated across all lanes, enables select the lanes.
    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        if ((r_state == c_REQ) && !r_load) begin
            if (r_lb) begin
                w_be    = 16'h0001 << r_addr[3:0];
                w_wdata = {16{r_wdata[7:0]}};
            end else if (r_lh) begin
                w_be    = 16'h0003 << {r_addr[3:1], 1'b0};
                w_wdata = {8{r_wdata[15:0]}};
            end else begin
                w_be    = 16'h000F << {r_addr[3:2], 2'b00};
                w_wdata = {4{r_wdata}};
            end
        end
    end

    assign req_ready    = (r_state == c_IDLE) & ~rst;
    assign lsu_stall    = (r_state != c_IDLE);
    assign dmem_req     = (r_state == c_REQ);
    assign dmem_we      = dmem_req & ~r_load;
    assign dmem_addr    = dmem_req ? {r_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
    assign dmem_be      = w_be;
    assign dmem_wdata   = w_wdata;
    assign resp_valid   = (r_state == c_RESP);
    assign resp_is_load = resp_valid & r_load;
    assign sel_lb       = r_lb;
    assign sel_lh       = r_lh;
    assign sel_lw       = r_lw;
    assign sel_unsigned = r_unsigned;
    assign sel_addr     = r_addr[OFFSET_BITS-1:0];
    assign sel_rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_access_ctrl
// Brief    : Self-checking bench for lsu_dmem_access_ctrl. A driver issues
//            requests and plays the memory; a reference model pushes the
//            expected transaction into a scoreboard queue; a monitor compares
//            DUT outputs against the queue head every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_access_ctrl;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 128;
    localparam int OFFSET_BITS = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid, req_ready, req_load, req_store;
    logic                   req_lb, req_lh, req_lw, req_unsigned;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [31:0]            req_wdata;
    logic                   dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [ADDR_WIDTH-1:0]  dmem_addr;
    logic [15:0]            dmem_be;
    logic [LINE_WIDTH-1:0]  dmem_wdata, dmem_rdata;
    logic                   sel_lb, sel_lh, sel_lw, sel_unsigned;
    logic [OFFSET_BITS-1:0] sel_addr;
    logic [LINE_WIDTH-1:0]  sel_rd_data;
    logic                   resp_valid, resp_is_load, lsu_stall, misalign_err;

    lsu_dmem_access_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_lb(req_lb), .req_lh(req_lh), .req_lw(req_lw),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .sel_lb(sel_lb), .sel_lh(sel_lh), .sel_lw(sel_lw),
        .sel_unsigned(sel_unsigned), .sel_addr(sel_addr), .sel_rd_data(sel_rd_data),
        .resp_valid(resp_valid), .resp_is_load(resp_is_load),
        .lsu_stall(lsu_stall), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    bit   in_resp  = 1'b0;
    logic [127:0] last_line  = '0;
    logic [3:0]   last_saddr = '0;

    typedef struct {
        bit           is_load;
        bit           mis;
        logic [31:0]  line_addr;
        logic [15:0]  be;
        logic [127:0] wdata;
        bit           lb, lh, lw, uns;
        logic [3:0]   saddr;
        logic [127:0] rd_line;
        int           t_acc;
        int           g_cyc;
        int           resp_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: lanes covered by the naturally aligned access window.
    function automatic exp_t model(input bit ld, input int sz, input bit uns,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [127:0] rd, input logic [127:0] prev_line);
        exp_t e;
        int   start;
        e.is_load = ld;
`ifdef LSU_MISALIGN_TRAP_EN
        e.mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`else
        e.mis = 1'b0;
`endif
        e.line_addr = addr & ~32'hF;
        start   = (int'(addr[3:0]) / sz) * sz;
        e.be    = '0;
        e.wdata = '0;
        if (!ld) begin
            for (int i = 0; i < 16; i++) begin
                if (i >= start && i < start + sz) e.be[i] = 1'b1;
                e.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
        end
        e.lb      = (sz == 1);
        e.lh      = (sz == 2);
        e.lw      = (sz == 4);
        e.uns     = uns;
        e.saddr   = addr[3:0];
        e.rd_line = (ld && !e.mis) ? rd : prev_line;
        e.t_acc   = 0;
        e.g_cyc   = 0;
        e.resp_cyc = 0;
        return e;
    endfunction

    // Issue one well-formed request and play the memory side.
    // Returns at #1 into the cycle where the response is expected.
    task automatic run_txn(input bit ld, input int sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gw, input int rw, input logic [127:0] rd,
                           input bit early, input bit stray);
        exp_t e;
        int   t;
        bit   use_early;
        use_early = early && in_resp;
        if (!use_early) begin
            if (in_resp && stray) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rnd128();
            end
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
        t = use_early ? cyc + 1 : cyc;
        req_valid    = 1'b1;
        req_load     = ld;
        req_store    = !ld;
        req_lb       = (sz == 1);
        req_lh       = (sz == 2);
        req_lw       = (sz == 4);
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        e = model(ld, sz, uns, addr, wd, rd, last_line);
        e.t_acc    = t;
        e.g_cyc    = e.mis ? t : t + 1 + gw;
        e.resp_cyc = e.mis ? t + 1 : (ld ? e.g_cyc + rw + 1 : e.g_cyc + 1);
        last_line  = e.rd_line;
        last_saddr = addr[3:0];
        sb.push_back(e);
        while (cyc < t + 1) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!e.mis) begin
            repeat (gw) begin @(posedge clk); #1; end
            dmem_gnt = 1'b1;
            if (ld && rw == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rd;
            end
            @(posedge clk); #1;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = rnd128();
            if (ld && rw > 0) begin
                repeat (rw - 1) begin @(posedge clk); #1; end
                dmem_rvalid = 1'b1;
                dmem_rdata  = rd;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                dmem_rdata  = rnd128();
            end
        end
        in_resp = 1'b1;
    endtask

    // Present a malformed request for one cycle; it must be dropped.
    task automatic run_bad(input int kind);
        if (in_resp) begin @(posedge clk); #1; end
        in_resp   = 1'b0;
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_wdata = $urandom;
        case (kind)
            0:       begin req_load = 1; req_store = 1; req_lb = 0; req_lh = 0; req_lw = 1; end
            1:       begin req_load = 0; req_store = 0; req_lb = 1; req_lh = 0; req_lw = 0; end
            2:       begin req_load = 1; req_store = 0; req_lb = 1; req_lh = 1; req_lw = 0; end
            default: begin req_load = 0; req_store = 1; req_lb = 0; req_lh = 0; req_lw = 0; end
        endcase
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bad_sel_addr", sel_addr, last_saddr);
        chk("bad_stall", lsu_stall, 1'b0);
    endtask

    // Monitor: compare every cycle against the scoreboard head.
    exp_t m_e;
    bit   m_stall;
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                chk("idle_dmem_req", dmem_req, 1'b0);
                chk("idle_stall", lsu_stall, 1'b0);
                chk("idle_ready", req_ready, 1'b1);
                chk("idle_resp", resp_valid, 1'b0);
            end else begin
                m_e     = sb[0];
                m_stall = (cyc >= m_e.t_acc + 1) && (cyc <= m_e.resp_cyc);
                chk("dmem_req", dmem_req, !m_e.mis && cyc >= m_e.t_acc + 1 && cyc <= m_e.g_cyc);
                chk("lsu_stall", lsu_stall, m_stall);
                chk("req_ready", req_ready, !m_stall);
                chk("resp_valid", resp_valid, cyc == m_e.resp_cyc);
                if (dmem_req) begin
                    chk("dmem_addr", dmem_addr, m_e.line_addr);
                    chk("dmem_we", dmem_we, !m_e.is_load);
                    chk("dmem_be", dmem_be, m_e.be);
                    chk("dmem_wdata", dmem_wdata, m_e.wdata);
                end
                if (cyc == m_e.resp_cyc) begin
                    chk("resp_is_load", resp_is_load, m_e.is_load);
                    chk("misalign_err", misalign_err, m_e.mis);
                    chk("sel_lb", sel_lb, m_e.lb);
                    chk("sel_lh", sel_lh, m_e.lh);
                    chk("sel_lw", sel_lw, m_e.lw);
                    chk("sel_unsigned", sel_unsigned, m_e.uns);
                    chk("sel_addr", sel_addr, m_e.saddr);
                    chk("sel_rd_data", sel_rd_data, m_e.rd_line);
                    void'(sb.pop_front());
                end else begin
                    chk("misalign_quiet", misalign_err, 1'b0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        bit          ld, uns, early, stray;
        int          sz;
        logic [31:0] a, w;

        req_valid = 0; req_load = 0; req_store = 0;
        req_lb = 0; req_lh = 0; req_lw = 0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_be", dmem_be, 16'h0);
        chk("rst_dmem_wdata", dmem_wdata, 128'h0);
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_resp_is_load", resp_is_load, 1'b0);
        chk("rst_stall", lsu_stall, 1'b0);
        chk("rst_sel_rd_data", sel_rd_data, 128'h0);
        chk("rst_sel_flags", {sel_lb, sel_lh, sel_lw, sel_unsigned, sel_addr}, 8'h0);
        chk("rst_misalign", misalign_err, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", req_ready, 1'b1);

        // Reset in the middle of a load waiting for read data
        req_valid = 1; req_load = 1; req_store = 0; req_lw = 1; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 0; req_load = 0; req_lw = 0;
        dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        chk("midrst_stall_before", lsu_stall, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stall_async", lsu_stall, 1'b0);
        chk("midrst_dmem_req", dmem_req, 1'b0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 128'hFEEDFACE_0BADF00D_CAFEBABE_DEADBEEF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("midrst_rd_data", sel_rd_data, 128'h0);
        chk("midrst_resp", resp_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 1'b1);
        @(negedge clk);
        chk("midrst_resp_after", resp_valid, 1'b0);
        dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_rvalid_ignored", sel_rd_data, 128'h0);
        chk("idle_rvalid_noresp", resp_valid, 1'b0);
        mon_en = 1'b1;

        // Directed cases
        run_txn(0, 1, 0, 32'h1005, 32'h000000AB, 0, 0, rnd128(), 0, 0);
        run_txn(1, 4, 0, 32'h2008, 32'h0, 0, 3,
                {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA} [127:0], 0, 1);
        run_txn(0, 2, 0, 32'h0000000E, 32'h00001234, 3, 0, rnd128(), 0, 0);
        run_txn(1, 4, 1, 32'h30000010, 32'h0, 1, 0, rnd128(), 1, 0);
        run_bad(0);
        run_txn(1, 4, 0, 32'h00000003, 32'h0, 0, 1, rnd128(), 0, 0);
        run_txn(1, 2, 1, 32'h00000005, 32'h0, 0, 2, rnd128(), 1, 0);
        run_txn(0, 4, 0, 32'h0000100E, 32'hA5A55A5A, 0, 0, rnd128(), 1, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_bad(int'($urandom_range(0, 3)));
            end else begin
                case ($urandom_range(0, 2))
                    0:       sz = 1;
                    1:       sz = 2;
                    default: sz = 4;
                endcase
                ld    = ($urandom_range(0, 1) == 1);
                uns   = ($urandom_range(0, 1) == 1);
                early = ($urandom_range(0, 1) == 1);
                stray = ($urandom_range(0, 1) == 1);
                a     = $urandom;
                w     = $urandom;
                run_txn(ld, sz, uns, a, w, int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), rnd128(), early, stray);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
